// File: rtl/rpn_defs.sv
// Shared definitions for the RPN calculator: opcodes, engine FSM states and
// the seven-segment glyphs (active-low, segment g in bit 6) used by the top level.
package rpn_defs;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_POP   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_MUL   = 3'd4,
    OP_DUP   = 3'd5,
    OP_SWAP  = 3'd6,
    OP_CLEAR = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_U     = 7'h41;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/reg_load_enable.sv
// Width-parametrised register with synchronous active-high reset and load enable.
module reg_load_enable #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/stack_ram.sv
// Single-port stack storage: synchronous write, registered read (read-before-write),
// contents are never reset.
module stack_ram #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN stack engine: TOS held in a register, deeper entries in stack_ram
// (entry under TOS at RAM[depth-2]); two-operand commands take three cycles.
module rpn_stack_engine
  import rpn_defs::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] tos,
  output logic [CNT_W-1:0] depth,
  output logic             empty,
  output logic             full,
  output logic             carry,
  output logic             err_overflow,
  output logic             err_underflow,
  output state_t           fsm_state
);

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in S_IDLE, so cmd_* is never sampled while busy.
  state_t            state, state_n;
  op_t               op_q, op_n;
  logic              tos_ld, depth_ld, ram_we;
  logic [WIDTH-1:0]  tos_d, ram_wdata, nos;
  logic [CNT_W-1:0]  depth_d;
  logic [ADDR_W-1:0] ram_addr;
  logic              carry_n, ovf_n, unf_n;
  logic [WIDTH:0]    sum;
  logic [2*WIDTH-1:0] prod;

  reg_load_enable #(.W(WIDTH)) u_tos (
    .clk(CLOCK_50), .rst(RESET), .load(tos_ld), .d(tos_d), .q(tos)
  );

  reg_load_enable #(.W(CNT_W)) u_depth (
    .clk(CLOCK_50), .rst(RESET), .load(depth_ld), .d(depth_d), .q(depth)
  );

  stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(CLOCK_50), .we(ram_we && !RESET), .addr(ram_addr),
    .wdata(ram_wdata), .rdata(nos)
  );

  assign cmd_ready = (state == S_IDLE);
  assign empty     = (depth == '0);
  assign full      = (depth == CNT_W'(DEPTH));
  assign fsm_state = state;
  assign sum       = {1'b0, nos} + {1'b0, tos};
  assign prod      = {{WIDTH{1'b0}}, nos} * {{WIDTH{1'b0}}, tos};

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state         <= S_IDLE;
      op_q          <= OP_PUSH;
      carry         <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_n;
      op_q          <= op_n;
      carry         <= carry_n;
      err_overflow  <= ovf_n;
      err_underflow <= unf_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    tos_ld    = 1'b0;
    tos_d     = tos;
    depth_ld  = 1'b0;
    depth_d   = depth;
    carry_n   = carry;
    ovf_n     = err_overflow;
    unf_n     = err_underflow;
    ram_we    = 1'b0;
    // Idle default keeps the NOS address presented so the read is in flight at accept.
    ram_addr  = ADDR_W'(depth - CNT_W'(2));
    ram_wdata = tos;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_PUSH: begin
              if (full) ovf_n = 1'b1;
              else begin
                ram_we   = !empty;
                ram_addr = ADDR_W'(depth - CNT_W'(1));
                tos_ld   = 1'b1;
                tos_d    = cmd_data;
                depth_ld = 1'b1;
                depth_d  = depth + CNT_W'(1);
              end
            end
            OP_DUP: begin
              if (empty)     unf_n = 1'b1;
              else if (full) ovf_n = 1'b1;
              else begin
                ram_we   = 1'b1;
                ram_addr = ADDR_W'(depth - CNT_W'(1));
                depth_ld = 1'b1;
                depth_d  = depth + CNT_W'(1);
              end
            end
            OP_POP: begin
              if (empty) unf_n = 1'b1;
              else if (depth == CNT_W'(1)) begin
                tos_ld   = 1'b1;
                tos_d    = '0;
                depth_ld = 1'b1;
                depth_d  = '0;
              end else begin
                op_n    = OP_POP;
                state_n = S_READ;
              end
            end
            OP_CLEAR: begin
              tos_ld   = 1'b1;
              tos_d    = '0;
              depth_ld = 1'b1;
              depth_d  = '0;
              carry_n  = 1'b0;
              ovf_n    = 1'b0;
              unf_n    = 1'b0;
            end
            default: begin
              if (depth < CNT_W'(2)) unf_n = 1'b1;
              else begin
                op_n    = op_t'(cmd_op);
                state_n = S_READ;
              end
            end
          endcase
        end
      end
      S_READ: state_n = S_EXEC;
      S_EXEC: begin
        state_n  = S_IDLE;
        tos_ld   = 1'b1;
        depth_ld = 1'b1;
        depth_d  = depth - CNT_W'(1);
        case (op_q)
          OP_POP: tos_d = nos;
          OP_ADD: begin
            tos_d   = sum[WIDTH-1:0];
            carry_n = sum[WIDTH];
          end
          OP_SUB: begin
            tos_d   = nos - tos;
            carry_n = (nos < tos);
          end
          OP_MUL: begin
            tos_d   = prod[WIDTH-1:0];
            carry_n = |prod[2*WIDTH-1:WIDTH];
          end
          default: begin
            tos_d    = nos;
            depth_ld = 1'b0;
            ram_we   = 1'b1;
            ram_wdata = tos;
          end
        endcase
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Bench for rpn_stack_engine (WIDTH=8, DEPTH=4): directed scenarios followed by
// random command streams, checked against a queue-based stack model.
module tb_rpn_stack_engine;
  import rpn_defs::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] tos;
  logic [CNT_W-1:0] depth;
  logic             empty, full, carry, err_overflow, err_underflow;
  state_t           fsm_state;

  rpn_stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLOCK_50(clk), .RESET(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .tos(tos), .depth(depth),
    .empty(empty), .full(full), .carry(carry), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected stack contents, bottom at index 0
  logic [WIDTH-1:0] exp_q[$];
  logic m_carry, m_ovf, m_unf;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_tos();
    return (exp_q.size() == 0) ? '0 : exp_q[exp_q.size()-1];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_carry = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Reference semantics; returns the number of cycles cmd_ready should stay low.
  task automatic model_apply(input logic [2:0] op, input logic [WIDTH-1:0] data, output int busy);
    int n;
    int a, b, r;
    logic [WIDTH-1:0] t;
    n = exp_q.size();
    busy = 0;
    case (op)
      3'd0: if (n == DEPTH) m_ovf = 1; else exp_q.push_back(data);
      3'd1: begin
        if (n == 0) m_unf = 1;
        else begin
          void'(exp_q.pop_back());
          if (n >= 2) busy = 2;
        end
      end
      3'd2, 3'd3, 3'd4: begin
        if (n < 2) m_unf = 1;
        else begin
          b = int'(exp_q.pop_back());
          a = int'(exp_q.pop_back());
          if (op == 3'd2) begin r = a + b; m_carry = (r > 255); end
          else if (op == 3'd3) begin r = a - b; m_carry = (a < b); end
          else begin r = a * b; m_carry = (r > 255); end
          exp_q.push_back(WIDTH'(r & 255));
          busy = 2;
        end
      end
      3'd5: begin
        if (n == 0) m_unf = 1;
        else if (n == DEPTH) m_ovf = 1;
        else exp_q.push_back(exp_q[n-1]);
      end
      3'd6: begin
        if (n < 2) m_unf = 1;
        else begin
          t = exp_q[n-1];
          exp_q[n-1] = exp_q[n-2];
          exp_q[n-2] = t;
          busy = 2;
        end
      end
      default: begin
        exp_q.delete();
        m_carry = 0; m_ovf = 0; m_unf = 0;
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".tos"},   tos,   m_tos());
    check_eq({tag, ".depth"}, depth, exp_q.size());
    check_eq({tag, ".empty"}, empty, exp_q.size() == 0);
    check_eq({tag, ".full"},  full,  exp_q.size() == DEPTH);
    check_eq({tag, ".carry"}, carry, m_carry);
    check_eq({tag, ".ovf"},   err_overflow,  m_ovf);
    check_eq({tag, ".unf"},   err_underflow, m_unf);
    check_eq({tag, ".ready"}, cmd_ready, 1);
  endtask

  // driver: issue one command, optionally holding cmd_valid (with a PUSH) while busy
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] data,
                        input bit hold_busy);
    int wait_n, busy, exp_busy;
    wait_n = 0;
    @(negedge clk);
    while (!cmd_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
    if (!cmd_ready) begin
      check_eq({tag, ".ready_timeout"}, cmd_ready, 1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk); #1;
    if (hold_busy) begin cmd_op = 3'd0; cmd_data = 8'h55; end
    else cmd_valid = 1'b0;
    model_apply(op, data, exp_busy);
    busy = 0;
    @(negedge clk);
    while (!cmd_ready && busy < 10) begin busy++; @(negedge clk); end
    cmd_valid = 1'b0;
    check_eq({tag, ".busy"}, busy, exp_busy);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    do_reset();
    check_outputs("reset");

    // 1: add
    do_cmd("t1.push5", 3'd0, 8'd5, 0);
    do_cmd("t1.push3", 3'd0, 8'd3, 0);
    do_cmd("t1.add",   3'd2, 8'd0, 0);
    // 2: sub borrow, mul overflow
    do_cmd("t2.push3", 3'd0, 8'd3, 0);
    do_cmd("t2.push5", 3'd0, 8'd5, 0);
    do_cmd("t2.sub",   3'd3, 8'd0, 0);
    do_cmd("t2.p10a",  3'd0, 8'h10, 0);
    do_cmd("t2.p10b",  3'd0, 8'h10, 0);
    do_cmd("t2.mul",   3'd4, 8'd0, 0);
    // 3: fill, overflow, drain
    do_cmd("t3.clear", 3'd7, 8'd0, 0);
    for (int i = 1; i <= 4; i++) do_cmd("t3.push", 3'd0, WIDTH'(i), 0);
    do_cmd("t3.push9", 3'd0, 8'd9, 0);
    for (int i = 0; i < 4; i++) do_cmd("t3.pop", 3'd1, 8'd0, 0);
    // 4: underflow stickiness, clear
    do_cmd("t4.pop",   3'd1, 8'd0, 0);
    do_cmd("t4.push7", 3'd0, 8'd7, 0);
    do_cmd("t4.add",   3'd2, 8'd0, 0);
    do_cmd("t4.clear", 3'd7, 8'd0, 0);
    // 5: swap, dup
    do_cmd("t5.pA",    3'd0, 8'h0A, 0);
    do_cmd("t5.pB",    3'd0, 8'h0B, 0);
    do_cmd("t5.swap",  3'd6, 8'd0, 0);
    do_cmd("t5.pop",   3'd1, 8'd0, 0);
    do_cmd("t5.dup",   3'd5, 8'd0, 0);
    do_cmd("t5.pop2",  3'd1, 8'd0, 0);
    // 6: cmd_valid held during busy, then reset in S_READ
    do_cmd("t6.p1",    3'd0, 8'd20, 0);
    do_cmd("t6.hold",  3'd2, 8'd0, 1);
    do_cmd("t6.p2",    3'd0, 8'd9, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("t6.rst");

    // random streams
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [2:0] op;
      r = $urandom_range(0, 19);
      if (r < 6)       op = 3'd0;
      else if (r < 19) op = 3'($urandom_range(1, 6));
      else             op = 3'd7;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_cmd("rand", op, 8'($urandom_range(0, 255)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
